// File: rtl/rpn_tokenizer.sv
// ASCII RPN tokenizer: turns a character stream into one calculator command per
// cycle and assembles signed 8-bit decimal literals.
module rpn_tokenizer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [2:0] op,
  output logic [7:0] val,
  output logic       apply,
  output logic       eol,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MINUS,
    S_NUM,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_MUL  = 3'd2,
    CMD_NEG  = 3'd3,
    CMD_POP  = 3'd4,
    CMD_PUSH = 3'd5,
    CMD_SWAP = 3'd6,
    CMD_DUP  = 3'd7
  } cmd_t;

  state_t      r_state;
  logic [8:0]  r_mag;
  logic        r_neg;
  logic [2:0]  r_op;
  logic [7:0]  r_val;
  logic        r_apply;
  logic        r_eol;
  logic        r_err;

  logic        w_is_digit;
  logic        w_is_minus;
  logic        w_is_op;
  logic        w_is_space;
  logic        w_is_nl;
  cmd_t        w_cmd;
  logic [3:0]  w_digit;
  logic [11:0] w_mag_next;
  logic [11:0] w_limit;
  logic [7:0]  w_lit;
  logic [7:0]  w_push_val;

  always_comb begin
    w_is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    w_is_minus = (char_in == 8'h2D);
    w_is_space = (char_in == 8'h20);
    w_is_nl    = (char_in == 8'h0A);
    w_is_op    = 1'b1;
    w_cmd      = CMD_ADD;
    case (char_in)
      8'h2B:   w_cmd = CMD_ADD;
      8'h2A:   w_cmd = CMD_MUL;
      8'h7E:   w_cmd = CMD_NEG;
      8'h70:   w_cmd = CMD_POP;
      8'h73:   w_cmd = CMD_SWAP;
      8'h64:   w_cmd = CMD_DUP;
      default: w_is_op = 1'b0;
    endcase
  end

  // Magnitude is range-checked before it is stored, so the 9-bit register never wraps.
  always_comb begin
    w_digit    = char_in[3:0];
    w_mag_next = 12'(r_mag) * 12'd10 + 12'(w_digit);
    w_limit    = r_neg ? 12'd128 : 12'd127;
    w_lit      = r_mag[7:0];
    w_push_val = r_neg ? (~w_lit + 8'd1) : w_lit;
  end

  // A pending token is flushed ahead of an operator/'-' without consuming it.
  assign char_ready = !(char_valid && (r_state == S_NUM || r_state == S_MINUS) &&
                        (w_is_op || w_is_minus));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_mag   <= '0;
      r_neg   <= 1'b0;
      r_op    <= '0;
      r_val   <= '0;
      r_apply <= 1'b0;
      r_eol   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_apply <= 1'b0;
      r_eol   <= 1'b0;
      if (char_valid) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_is_digit) begin
              r_mag   <= 9'(w_digit);
              r_neg   <= 1'b0;
              r_state <= S_NUM;
            end else if (w_is_minus) begin
              r_state <= S_MINUS;
            end else if (w_is_op) begin
              r_apply <= 1'b1;
              r_op    <= w_cmd;
              r_val   <= '0;
            end else if (w_is_nl) begin
              r_eol <= 1'b1;
            end else if (!w_is_space) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_MINUS: begin
            if (w_is_digit) begin
              r_mag   <= 9'(w_digit);
              r_neg   <= 1'b1;
              r_state <= S_NUM;
            end else if (w_is_space || w_is_nl || w_is_op || w_is_minus) begin
              r_apply <= 1'b1;
              r_op    <= CMD_SUB;
              r_val   <= '0;
              r_eol   <= w_is_nl;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_NUM: begin
            if (w_is_digit) begin
              if (w_mag_next > w_limit) begin
                r_err   <= 1'b1;
                r_state <= S_ERR;
              end else begin
                r_mag <= w_mag_next[8:0];
              end
            end else if (w_is_space || w_is_nl || w_is_op || w_is_minus) begin
              r_apply <= 1'b1;
              r_op    <= CMD_PUSH;
              r_val   <= w_push_val;
              r_eol   <= w_is_nl;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
          S_ERR: begin
            if (w_is_nl) begin
              r_eol   <= 1'b1;
              r_err   <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign op    = r_op;
  assign val   = r_val;
  assign apply = r_apply;
  assign eol   = r_eol;
  assign err   = r_err;

endmodule

// File: tb/tb_rpn_tokenizer.sv
// Scoreboard bench for rpn_tokenizer: expected command/eol events are queued as
// characters are sent and compared whenever apply or eol pulses.
module tb_rpn_tokenizer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [2:0] op;
  logic [7:0] val;
  logic       apply;
  logic       eol;
  logic       err;

  typedef struct {
    logic       ap;
    logic [2:0] op;
    logic [7:0] val;
    logic       eol;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, PUSH = 3'd5, DUP = 3'd7;

  rpn_tokenizer dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .op        (op),
    .val       (val),
    .apply     (apply),
    .eol       (eol),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_cmd(input logic [2:0] o, input logic [7:0] v, input logic e);
    sb.push_back('{1'b1, o, v, e});
  endtask

  task automatic expect_eol();
    sb.push_back('{1'b0, 3'd0, 8'd0, 1'b1});
  endtask

  // Drives one character, holding it through any stall, and checks the stall length.
  task automatic send(input byte c, input int exp_stall);
    int st = 0;
    @(negedge clk);
    char_in    = c;
    char_valid = 1'b1;
    #1;
    while (!char_ready && st < 4) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      st++;
    end
    @(posedge clk);
    #1;
    chk($sformatf("stall_%c", c), st, exp_stall);
  endtask

  task automatic send_str(input string s, input string stl);
    for (int i = 0; i < s.len(); i++) send(s[i], (stl[i] == "1") ? 1 : 0);
  endtask

  task automatic idle_drain(input string tag);
    @(negedge clk);
    char_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && (apply || eol)) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("apply", int'(apply), int'(e.ap));
        chk("eol", int'(eol), int'(e.eol));
        if (e.ap) begin
          chk("op", int'(op), int'(e.op));
          chk("val", int'(val), int'(e.val));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_op", int'(op), 0);
    chk("rst_val", int'(val), 0);
    chk("rst_apply", int'(apply), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(char_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    expect_cmd(PUSH, 8'd12, 1'b0);
    expect_cmd(PUSH, 8'd5, 1'b0);
    expect_cmd(ADD, 8'd0, 1'b0);
    expect_eol();
    send_str("12 5+\n", "000010");
    idle_drain("drain_t1");

    expect_cmd(PUSH, 8'hF9, 1'b0);
    expect_cmd(PUSH, 8'd3, 1'b0);
    expect_cmd(SUB, 8'd0, 1'b1);
    send_str("-7 3-\n", "000010");
    idle_drain("drain_t2");

    expect_cmd(PUSH, 8'h80, 1'b0);
    expect_cmd(PUSH, 8'd127, 1'b0);
    expect_cmd(MUL, 8'd0, 1'b0);
    expect_eol();
    send_str("-128 127*\n", "0000000010");
    send_str("128 ", "0000");
    chk("ovf_err", int'(err), 1);
    expect_eol();
    send_str("\n", "0");
    chk("ovf_err_clr", int'(err), 0);
    idle_drain("drain_t3");

    expect_eol();
    send_str("-129\n", "00000");
    chk("negovf_err_clr", int'(err), 0);
    expect_cmd(PUSH, 8'd0, 1'b0);
    send_str("-0 ", "000");
    idle_drain("drain_t4");

    expect_cmd(SUB, 8'd0, 1'b0);
    expect_cmd(ADD, 8'd0, 1'b0);
    expect_cmd(DUP, 8'd0, 1'b0);
    expect_eol();
    send_str("-+d\n", "0100");
    idle_drain("drain_t5");

    send_str("3x", "00");
    chk("inv_err", int'(err), 1);
    expect_eol();
    send_str("4 5\n", "0000");
    chk("inv_err_clr", int'(err), 0);
    expect_cmd(PUSH, 8'd9, 1'b0);
    send_str("9 ", "00");
    idle_drain("drain_t6");

    send_str("4", "0");
    #2;
    rst        = 1'b0;
    char_valid = 1'b0;
    #1;
    chk("mid_rst_op", int'(op), 0);
    chk("mid_rst_val", int'(val), 0);
    chk("mid_rst_apply", int'(apply), 0);
    chk("mid_rst_eol", int'(eol), 0);
    chk("mid_rst_ready", int'(char_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    expect_cmd(PUSH, 8'd2, 1'b0);
    send_str("2 ", "00");
    idle_drain("drain_t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
